// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - big-endian byte-lane data memory; optional power-on zero sweep under DMEM_ZERO_INIT_EN
module dmem_bytelane #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_ld_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        misaligned_o,
  output logic        busy_o
);

  localparam int WORDS = DEPTH / 4;
  localparam int WAW   = AW - 2;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
`ifdef DMEM_ZERO_INIT_EN
    S_CLEAR = 2'd1,
`endif
    S_IDLE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Lane 0 holds the most significant byte of each word.
  logic [7:0] mem_q [0:3][0:WORDS-1];

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        mis_q, mis_d;

  logic            clr_we;
  logic [WAW-1:0]  clr_idx;
  logic            busy;
  logic            accept;
  logic            is_store;
  logic            is_load;
  logic            bad_align;
  logic [1:0]      lane;
  logic [WAW-1:0]  word_idx;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic            ext_bit;
  logic [3:0]      lane_we;
  logic [7:0]      lane_wd [0:3];
  logic [WAW-1:0]  wr_idx;
  logic            unused_addr;

  assign unused_addr = ^addr_i[31:AW];

`ifdef DMEM_ZERO_INIT_EN
  logic [WAW-1:0] sweep_q, sweep_d;

  // State and sweep counter; reset restarts the sweep at word 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state: the first cycle out of reset already clears word 0,
  // so busy lasts exactly WORDS cycles after reset falls.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_we  = 1'b0;
    case (state_q)
      S_RESET: begin
        clr_we  = 1'b1;
        sweep_d = WAW'(1);
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        if (sweep_q == WAW'(WORDS - 1)) begin
          sweep_d = '0;
          state_d = S_IDLE;
        end else begin
          sweep_d = sweep_q + WAW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign clr_idx = sweep_q;
  assign busy    = (state_q != S_IDLE);
`else
  // State register; without the sweep it only tracks reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave reset straight into normal operation.
  always_comb begin
    state_d = S_IDLE;
    clr_we  = 1'b0;
    if (state_q != S_RESET) begin
      state_d = S_IDLE;
    end
  end

  assign clr_idx = '0;
  assign busy    = 1'b0;
`endif

  assign lane      = addr_i[1:0];
  assign word_idx  = addr_i[AW-1:2];
  assign accept    = !rst_i && !busy && (mem_read_i || mem_write_i);
  assign is_store  = mem_write_i;
  assign is_load   = mem_read_i && !mem_write_i;
  assign bad_align = (size_i == 2'b11) ||
                     (size_i == 2'b01 && addr_i[0]) ||
                     (size_i == 2'b10 && addr_i[1:0] != 2'b00);

  // Write port: sweep zeroing has priority, else an accepted aligned store.
  always_comb begin
    lane_we = 4'b0000;
    wr_idx  = word_idx;
    for (int l = 0; l < 4; l++) lane_wd[l] = 8'h00;
    if (clr_we && !rst_i) begin
      lane_we = 4'b1111;
      wr_idx  = clr_idx;
    end else if (accept && is_store && !bad_align) begin
      case (size_i)
        2'b00: begin
          lane_we[lane] = 1'b1;
          for (int l = 0; l < 4; l++) lane_wd[l] = wdata_i[7:0];
        end
        2'b01: begin
          lane_we    = addr_i[1] ? 4'b1100 : 4'b0011;
          lane_wd[0] = wdata_i[15:8];
          lane_wd[1] = wdata_i[7:0];
          lane_wd[2] = wdata_i[15:8];
          lane_wd[3] = wdata_i[7:0];
        end
        default: begin
          lane_we    = 4'b1111;
          lane_wd[0] = wdata_i[31:24];
          lane_wd[1] = wdata_i[23:16];
          lane_wd[2] = wdata_i[15:8];
          lane_wd[3] = wdata_i[7:0];
        end
      endcase
    end
  end

  // Byte-lane array update.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we[l]) mem_q[l][wr_idx] <= lane_wd[l];
    end
  end

  assign rd_word = {mem_q[0][word_idx], mem_q[1][word_idx],
                    mem_q[2][word_idx], mem_q[3][word_idx]};
  assign rd_half = addr_i[1] ? rd_word[15:0] : rd_word[31:16];

  // Pick the addressed byte out of the big-endian word.
  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  // Load result and strobes; rdata only changes on an accepted load.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = accept && is_load;
    mis_d    = accept && bad_align;
    ext_bit  = 1'b0;
    if (accept && is_load) begin
      if (bad_align) begin
        rdata_d = 32'h0;
      end else begin
        case (size_i)
          2'b00: begin
            ext_bit = !unsigned_ld_i && rd_byte[7];
            rdata_d = {{24{ext_bit}}, rd_byte};
          end
          2'b01: begin
            ext_bit = !unsigned_ld_i && rd_half[15];
            rdata_d = {{16{ext_bit}}, rd_half};
          end
          default: rdata_d = rd_word;
        endcase
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign misaligned_o = mis_q;
  assign busy_o       = busy;

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - directed vector bench for dmem_bytelane
module tb_dmem_bytelane;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misaligned;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_bytelane #(.DEPTH(256)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mem_read_i(mem_read),
    .mem_write_i(mem_write),
    .size_i(size),
    .unsigned_ld_i(unsigned_ld),
    .addr_i(addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .rvalid_o(rvalid),
    .misaligned_o(misaligned),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_rv;
    logic        exp_mis;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    unsigned_ld = u;
    addr        = a;
    wdata       = wd;
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    drive(rd, wr, sz, u, a, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  // Count posedges after reset release until busy drops, with a bound.
  task automatic count_busy(output int n, output int rv_seen);
    n = 0;
    rv_seen = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid || misaligned) rv_seen++;
    end while (busy && n < 200);
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic u, input logic [31:0] a,
                              input logic [31:0] wd, input logic rv, input logic mis,
                              input logic [31:0] exprd);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.sz = sz; v.u = u; v.a = a; v.wd = wd;
    v.exp_rv = rv; v.exp_mis = mis; v.exp_rd = exprd;
    return v;
  endfunction

  initial begin
    int n;
    int rv_seen;
    logic [31:0] hold;

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset_misaligned", {31'h0, misaligned}, 32'h0);
`ifdef DMEM_ZERO_INIT_EN
    chk("reset_busy", {31'h0, busy}, 32'h1);
    // Release reset with a word load at 0xFC held throughout the sweep.
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0);
    count_busy(n, rv_seen);
    chk("sweep_busy_cycles", n, 32'd64);
    chk("busy_load_dropped", rv_seen, 32'd0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0);
    chk("post_sweep_rvalid", {31'h0, rvalid}, 32'h1);
    chk("post_sweep_lw_fc", rdata, 32'h0);
    // Dirty word 0xFC, then reset mid-sweep; the restarted sweep must clear it.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_00FC, 32'h1122_3344);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0);
    chk("dirty_lw_fc", rdata, 32'h1122_3344);
    pulse_reset();
    rst = 1'b0;
    repeat (30) @(posedge clk);
    pulse_reset();
    rst = 1'b0;
    count_busy(n, rv_seen);
    chk("midsweep_busy_cycles", n, 32'd64);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0);
    chk("resweep_lw_fc", rdata, 32'h0);
`else
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", {31'h0, busy}, 32'h0);
`endif
    go_idle();

    //          name            rd wr  sz    u  addr           wdata          rv mis rdata
    vecs.push_back(mk("sw_10",   0, 1, 2'b10, 0, 32'h0000_0010, 32'h8899_AABB, 0, 0, 32'h0));
    vecs.push_back(mk("lb_11",   1, 0, 2'b00, 0, 32'h0000_0011, 32'h0,         1, 0, 32'hFFFF_FF99));
    vecs.push_back(mk("lbu_11",  1, 0, 2'b00, 1, 32'h0000_0011, 32'h0,         1, 0, 32'h0000_0099));
    vecs.push_back(mk("lh_12",   1, 0, 2'b01, 0, 32'h0000_0012, 32'h0,         1, 0, 32'hFFFF_AABB));
    vecs.push_back(mk("lhu_12",  1, 0, 2'b01, 1, 32'h0000_0012, 32'h0,         1, 0, 32'h0000_AABB));
    vecs.push_back(mk("lw_10",   1, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         1, 0, 32'h8899_AABB));
    vecs.push_back(mk("lb_10",   1, 0, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 0, 32'hFFFF_FF88));
    vecs.push_back(mk("lh_10",   1, 0, 2'b01, 0, 32'h0000_0010, 32'h0,         1, 0, 32'hFFFF_8899));
    vecs.push_back(mk("sb_13",   0, 1, 2'b00, 0, 32'h0000_0013, 32'hFFFF_FF5A, 0, 0, 32'h0));
    vecs.push_back(mk("lw_10b",  1, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         1, 0, 32'h8899_AA5A));
    vecs.push_back(mk("sw_20",   0, 1, 2'b10, 0, 32'h0000_0020, 32'h0102_0304, 0, 0, 32'h0));
    vecs.push_back(mk("sh_21",   0, 1, 2'b01, 0, 32'h0000_0021, 32'h0000_1234, 0, 1, 32'h0));
    vecs.push_back(mk("lw_20",   1, 0, 2'b10, 0, 32'h0000_0020, 32'h0,         1, 0, 32'h0102_0304));
    vecs.push_back(mk("lw_22",   1, 0, 2'b10, 0, 32'h0000_0022, 32'h0,         1, 1, 32'h0));
    vecs.push_back(mk("sw_104",  0, 1, 2'b10, 0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0));
    vecs.push_back(mk("lw_04",   1, 0, 2'b10, 0, 32'h0000_0004, 32'h0,         1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("rdwr_30", 1, 1, 2'b10, 0, 32'h0000_0030, 32'hCAFE_F00D, 0, 0, 32'h0));
    vecs.push_back(mk("lw_30",   1, 0, 2'b10, 0, 32'h0000_0030, 32'h0,         1, 0, 32'hCAFE_F00D));
    vecs.push_back(mk("sh_32",   0, 1, 2'b01, 0, 32'h0000_0032, 32'hFFFF_7F80, 0, 0, 32'h0));
    vecs.push_back(mk("lh_32",   1, 0, 2'b01, 0, 32'h0000_0032, 32'h0,         1, 0, 32'h0000_7F80));
    vecs.push_back(mk("lb_33",   1, 0, 2'b00, 0, 32'h0000_0033, 32'h0,         1, 0, 32'hFFFF_FF80));
    vecs.push_back(mk("lhu_30",  1, 0, 2'b01, 1, 32'h0000_0030, 32'h0,         1, 0, 32'h0000_CAFE));
    vecs.push_back(mk("lb_31",   1, 0, 2'b00, 0, 32'h0000_0031, 32'h0,         1, 0, 32'hFFFF_FFFE));
    vecs.push_back(mk("lw_30b",  1, 0, 2'b10, 0, 32'h0000_0030, 32'h0,         1, 0, 32'hCAFE_7F80));
    vecs.push_back(mk("lrsv_40", 1, 0, 2'b11, 0, 32'h0000_0040, 32'h0,         1, 1, 32'h0));
    vecs.push_back(mk("lw_30c",  1, 0, 2'b10, 0, 32'h0000_0030, 32'h0,         1, 0, 32'hCAFE_7F80));
    vecs.push_back(mk("lh_41",   1, 0, 2'b01, 0, 32'h0000_0041, 32'h0,         1, 1, 32'h0));
    vecs.push_back(mk("lw_04b",  1, 0, 2'b10, 0, 32'h0000_0104, 32'h0,         1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("nop",     0, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("srsv_20", 0, 1, 2'b11, 0, 32'h0000_0020, 32'hFFFF_FFFF, 0, 1, 32'h0));
    vecs.push_back(mk("lw_20b",  1, 0, 2'b10, 0, 32'h0000_0020, 32'h0,         1, 0, 32'h0102_0304));

    hold = rdata;
    foreach (vecs[i]) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd);
      if (vecs[i].exp_rv) hold = vecs[i].exp_rd;
      chk({vecs[i].name, "_rvalid"}, {31'h0, rvalid}, {31'h0, vecs[i].exp_rv});
      chk({vecs[i].name, "_mis"}, {31'h0, misaligned}, {31'h0, vecs[i].exp_mis});
      chk({vecs[i].name, "_rdata"}, rdata, hold);
    end
    go_idle();

    // Strobes are single-cycle pulses.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0022, 32'h0);
    chk("pulse_mis_hi", {31'h0, misaligned}, 32'h1);
    go_idle();
    @(posedge clk);
    #1;
    chk("pulse_mis_lo", {31'h0, misaligned}, 32'h0);
    chk("pulse_rvalid_lo", {31'h0, rvalid}, 32'h0);

    // Reset clears the output registers even with a held rdata.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    chk("pre_reset_rdata", rdata, 32'h8899_AA5A);
    pulse_reset();
    chk("rereset_rdata", rdata, 32'h0);
    chk("rereset_rvalid", {31'h0, rvalid}, 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
